// File: rtl/ring_decoder.sv
// Monitor and index decoder for a one-hot ring counter: locks onto a legal
// rotation, reports the current position, advance/lap pulses and sequence violations.
module ring_decoder #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int LOCK_CNT = 2,
    parameter int LAP_W    = 8,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     ring_in,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             step,
    output logic             lap,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W  = $clog2(N + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [N-1:0]        r_smp;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [GOOD_W-1:0]   r_good, w_good_nxt;
    logic                r_step, w_step_nxt;
    logic                r_lap, w_lap_nxt;
    logic                r_err, w_err_nxt;
    logic [LAP_W-1:0]    r_lap_cnt, w_lap_cnt_nxt;
    logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;

    logic [CNT_W-1:0]    w_ones;
    logic [IDX_W-1:0]    w_k;
    logic                w_legal;
    logic [IDX_W-1:0]    w_nxt;
    logic [GOOD_W-1:0]   w_good_inc;

    // Population count and position of the set bit in the sampled ring.
    always_comb begin
        w_ones = '0;
        w_k    = '0;
        for (int i = 0; i < N; i++) begin
            if (r_smp[i]) begin
                w_ones = w_ones + 1'b1;
                w_k    = IDX_W'(i);
            end
        end
    end

    assign w_legal    = (w_ones == CNT_W'(1));
    assign w_nxt      = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + 1'b1;
    assign w_good_inc = r_good + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_good_nxt    = r_good;
        w_step_nxt    = 1'b0;
        w_lap_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_lap_cnt_nxt = r_lap_cnt;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            HUNT: begin
                if (w_legal) begin
                    w_idx_nxt   = w_k;
                    w_good_nxt  = '0;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!w_legal) begin
                    w_state_nxt = HUNT;
                end else if (w_k == w_nxt) begin
                    w_idx_nxt  = w_k;
                    w_good_nxt = w_good_inc;
                    if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                        w_state_nxt = LOCKED;
                    end
                end else if (w_k != r_idx) begin
                    w_idx_nxt  = w_k;
                    w_good_nxt = '0;
                end
            end
            LOCKED: begin
                if (w_legal && (w_k == w_nxt)) begin
                    w_idx_nxt  = w_k;
                    w_step_nxt = 1'b1;
                    if (r_idx == IDX_W'(N - 1)) begin
                        w_lap_nxt     = 1'b1;
                        w_lap_cnt_nxt = r_lap_cnt + 1'b1;
                    end
                end else if (!(w_legal && (w_k == r_idx))) begin
                    // Violation: idx keeps the last good position for diagnosis.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = HUNT;
                    if (r_err_cnt != '1) begin
                        w_err_cnt_nxt = r_err_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= HUNT;
            r_smp     <= '0;
            r_idx     <= '0;
            r_good    <= '0;
            r_step    <= 1'b0;
            r_lap     <= 1'b0;
            r_err     <= 1'b0;
            r_lap_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_smp     <= ring_in;
            r_idx     <= w_idx_nxt;
            r_good    <= w_good_nxt;
            r_step    <= w_step_nxt;
            r_lap     <= w_lap_nxt;
            r_err     <= w_err_nxt;
            r_lap_cnt <= w_lap_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign idx         = r_idx;
    assign valid       = (r_state == LOCKED);
    assign step        = r_step;
    assign lap         = r_lap;
    assign lap_cnt     = r_lap_cnt;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder: lock-in, stepping, laps, violations,
// stalls, error saturation and asynchronous reset.
module tb_ring_decoder;

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic       clk;
    logic       reset;
    logic [3:0] ring_in;
    logic [1:0] idx;
    logic       valid;
    logic       step;
    logic       lap;
    logic [7:0] lap_cnt;
    logic       err;
    logic [3:0] err_cnt;
    logic [1:0] o_dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    ring_decoder #(.N(4), .IDX_W(2), .LOCK_CNT(2), .LAP_W(8), .ERR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ring_in    (ring_in),
        .idx        (idx),
        .valid      (valid),
        .step       (step),
        .lap        (lap),
        .lap_cnt    (lap_cnt),
        .err        (err),
        .err_cnt    (err_cnt),
        .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a pattern; it lands in the sample register on this edge and
    // reaches the outputs one edge later.
    task automatic apply(input logic [3:0] v);
        ring_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(o_dbg_state), 32'(S_HUNT));
        check({tag, "_idx"}, 32'(idx), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_step"}, 32'(step), 0);
        check({tag, "_lap"}, 32'(lap), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_lap_cnt"}, 32'(lap_cnt), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    int exp_err_cnt;
    int exp_lap_cnt;

    initial begin
        // Reset held with a legal pattern on the input
        reset   = 1'b0;
        ring_in = 4'b0001;
        #12;
        check_all_zero("rst");
        reset = 1'b1;

        apply(4'b0001);
        check("hunt_after_rst", 32'(o_dbg_state), 32'(S_HUNT));
        apply(4'b0001);
        check("enter_check", 32'(o_dbg_state), 32'(S_CHECK));
        check("enter_check_idx", 32'(idx), 0);
        check("enter_check_valid", 32'(valid), 0);
        apply(4'b0001);
        check("check_stall_state", 32'(o_dbg_state), 32'(S_CHECK));
        check("check_stall_step", 32'(step), 0);
        check("check_stall_err", 32'(err), 0);

        // Rotation: lock after two good advances
        apply(4'b0010);
        check("rot_stall_state", 32'(o_dbg_state), 32'(S_CHECK));
        apply(4'b0100);
        check("good1_idx", 32'(idx), 1);
        check("good1_valid", 32'(valid), 0);
        apply(4'b1000);
        check("lock_valid", 32'(valid), 1);
        check("lock_idx", 32'(idx), 2);
        check("lock_no_step", 32'(step), 0);
        apply(4'b0001);
        check("step3_step", 32'(step), 1);
        check("step3_idx", 32'(idx), 3);
        check("step3_lap", 32'(lap), 0);
        apply(4'b0010);
        check("wrap_step", 32'(step), 1);
        check("wrap_lap", 32'(lap), 1);
        check("wrap_idx", 32'(idx), 0);
        check("wrap_lap_cnt", 32'(lap_cnt), 1);

        // Skip from position 1 to position 3
        apply(4'b1000);
        check("pos1_step", 32'(step), 1);
        check("pos1_idx", 32'(idx), 1);
        check("pos1_lap", 32'(lap), 0);
        apply(4'b1000);
        check("skip_err", 32'(err), 1);
        check("skip_step", 32'(step), 0);
        check("skip_err_cnt", 32'(err_cnt), 1);
        check("skip_valid", 32'(valid), 0);
        check("skip_idx_hold", 32'(idx), 1);
        check("skip_state", 32'(o_dbg_state), 32'(S_HUNT));
        apply(4'b0001);
        check("skip_err_one_cycle", 32'(err), 0);
        check("rehunt_state", 32'(o_dbg_state), 32'(S_CHECK));
        check("rehunt_idx", 32'(idx), 3);
        apply(4'b0010);
        check("relock_good1", 32'(idx), 0);
        apply(4'b0100);
        check("relock_valid", 32'(valid), 1);
        check("relock_idx", 32'(idx), 1);

        // Stall while locked
        apply(4'b0100);
        check("pre_stall_step", 32'(step), 1);
        check("pre_stall_idx", 32'(idx), 2);
        for (int i = 0; i < 4; i++) begin
            apply(4'b0100);
            check("stall_valid", 32'(valid), 1);
            check("stall_step", 32'(step), 0);
            check("stall_err", 32'(err), 0);
            check("stall_idx", 32'(idx), 2);
        end
        apply(4'b1000);
        check("stall_tail_step", 32'(step), 0);
        apply(4'b1000);
        check("resume_step", 32'(step), 1);
        check("resume_idx", 32'(idx), 3);

        // Multi-hot then all-zero: only the first violation counts
        apply(4'b0110);
        check("mh_pre_err", 32'(err), 0);
        apply(4'b0000);
        check("mh_err", 32'(err), 1);
        check("mh_err_cnt", 32'(err_cnt), 2);
        check("mh_idx_hold", 32'(idx), 3);
        apply(4'b0001);
        check("zero_no_err", 32'(err), 0);
        check("zero_err_cnt", 32'(err_cnt), 2);
        check("zero_state", 32'(o_dbg_state), 32'(S_HUNT));
        apply(4'b0010);
        check("mh_rehunt", 32'(o_dbg_state), 32'(S_CHECK));
        apply(4'b0100);
        check("mh_good1", 32'(valid), 0);
        apply(4'b1000);
        check("mh_relock", 32'(valid), 1);
        check("mh_relock_idx", 32'(idx), 2);
        apply(4'b0001);
        check("mh_step", 32'(step), 1);
        apply(4'b0001);
        check("mh_lap", 32'(lap), 1);
        check("mh_lap_cnt", 32'(lap_cnt), 2);

        // Repeated violations: error counter saturates at 15
        exp_err_cnt = 2;
        exp_lap_cnt = 2;
        for (int i = 0; i < 18; i++) begin
            apply(4'b0000);
            apply(4'b0001);
            exp_err_cnt = (exp_err_cnt == 15) ? 15 : exp_err_cnt + 1;
            check("sat_err", 32'(err), 1);
            check("sat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
            apply(4'b0010);
            apply(4'b0100);
            apply(4'b1000);
            apply(4'b0001);
            apply(4'b0001);
            exp_lap_cnt++;
            check("sat_lap", 32'(lap), 1);
            check("sat_lap_cnt", 32'(lap_cnt), 32'(exp_lap_cnt));
        end
        check("sat_final", 32'(err_cnt), 15);
        check("sat_valid", 32'(valid), 1);

        // Asynchronous reset mid-lap, checked before any clock edge
        apply(4'b0010);
        check("midlap_valid", 32'(valid), 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
